mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-004 MemRead  in  1  load request from the control decoder.
REQ-005 MemWrite  in  1  store request.
REQ-006 MemDataSize  in  2  access size: 11 word, 10 halfword, 01 byte, 00 illegal.
REQ-007 MemDataSign  in  1  1 means sign-extend loads, 0 means zero-extend; ignored for stores.
REQ-008 Address  in  32  byte address from the ALU.
REQ-009 WriteData  in  32  store data; the byte or halfword is taken from the low bits.
REQ-010 ReadData  out  32  extended load result.
REQ-011 Stall  out  1  pipeline hold request.
REQ-012 Misaligned  out  1  alignment or illegal-size error pulse.
REQ-013 mem_req, mem_we  out  1 each  memory transaction request and write enable.
REQ-014 mem_addr  out  32  word-aligned address; bits [1:0] are always 00.
REQ-015 mem_wdata  out  32  memory write word.
REQ-016 mem_rdata  in  32  memory read word, valid when mem_ack is high.
REQ-017 mem_ack  in  1  transaction complete.

Function
REQ-018 Byte lanes SHALL be little-endian: byte n occupies bits [8n+7:8n]; halfword n occupies bits [16n+15:16n].
REQ-019 The FSM SHALL have states IDLE, READ, RMW_READ, RMW_WRITE, WRITE and DONE.
REQ-020 In IDLE with MemRead or MemWrite high, the access SHALL be misaligned when: size is 11 and Address[1:0] is not 00, size is 10 and Address[0] is 1, or size is 00.
REQ-021 A misaligned access SHALL assert Misaligned combinationally, leave Stall at 0, start no transaction, leave ReadData unchanged, and keep the FSM in IDLE.
REQ-022 On a legal request in IDLE, the unit SHALL assert Stall combinationally in that same cycle and latch address, size, sign and data.
REQ-023 From IDLE, a legal request SHALL go to: WRITE for a word store, RMW_READ for a sub-word store, READ for a load.
REQ-024 If MemRead and MemWrite are both high, the access SHALL be treated as a store.
REQ-025 mem_req SHALL be high in READ, RMW_READ, RMW_WRITE and WRITE, and low in IDLE and DONE.
REQ-026 mem_we SHALL be 1 only in WRITE and RMW_WRITE.
REQ-027 mem_addr and mem_wdata SHALL be held stable while mem_req is high and mem_ack is low.
REQ-028 Each state SHALL wait indefinitely for mem_ack; one mem_ack SHALL complete exactly one transaction.
REQ-029 In READ, on mem_ack the unit SHALL select the lane given by the latched Address, sign- or zero-extend it to 32 bits, register it into ReadData, and go to DONE.
REQ-030 In RMW_READ, on mem_ack the unit SHALL capture mem_rdata, replace only the addressed byte or halfword lane with WriteData[7:0] or [15:0], and go to RMW_WRITE.
REQ-031 In RMW_WRITE and in WRITE, on mem_ack the unit SHALL go to DONE.
REQ-032 In DONE the unit SHALL drive Stall at 0 and go to IDLE on the next clock.
REQ-033 Stall SHALL be 1 in READ, RMW_READ, RMW_WRITE and WRITE.
REQ-034 Latency with zero-wait memory: load or word store SHALL stall 2 cycles; sub-word store SHALL stall 3 cycles.
REQ-035 ReadData SHALL hold its value until the next load completes; stores SHALL NOT change it.
REQ-036 Request inputs changing while the FSM is not in IDLE SHALL be ignored.

Reset
REQ-037 While reset is high, the FSM SHALL be in IDLE and mem_req, mem_we, Stall and Misaligned SHALL be 0.
REQ-038 While reset is high, ReadData, mem_addr and mem_wdata SHALL be 0x00000000.
REQ-039 Reset asserted mid-transaction SHALL abort it immediately with no memory write completed; an mem_ack arriving during reset SHALL be ignored.

Verification
REQ-040 LB with Address 0x00000013, memory word 0x80FF7F01, MemDataSign=1 -> ReadData 0xFFFFFF80; the same access with MemDataSign=0 -> 0x00000080.
REQ-041 LH with Address 0x00000012, memory word 0x80FF7F01, signed -> ReadData 0xFFFF80FF; mem_addr 0x00000010; Stall high for 2 cycles with zero-wait memory.
REQ-042 SB with Address 0x00000011, WriteData 0x000000AB, memory word 0x11223344 -> RMW read, then a write of 0x1122AB44 to 0x00000010; Stall high for 3 cycles.
REQ-043 LW with Address 0x00000002 -> Misaligned=1 for that cycle, Stall=0, mem_req never asserted; a halfword access at 0x00000001 gives the same result.
REQ-044 A word store whose mem_ack is delayed 4 cycles -> mem_req, mem_addr and mem_wdata stay stable for all 4 cycles, and Stall falls exactly in the DONE cycle.
REQ-045 Reset asserted in RMW_WRITE before mem_ack -> mem_req drops immediately, the FSM is in IDLE, and a following LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store unit that turns byte, halfword and word accesses into
//            word-aligned memory transactions, with read-modify-write for
//            sub-word stores.
// Revision : 1.0
// ============================================================================
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemDataSize,
    input  logic        MemDataSign,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        RMW_READ  = 3'd2,
        RMW_WRITE = 3'd3,
        WRITE     = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    state_t      state;
    state_t      state_next;
    logic [1:0]  lat_lane;
    logic [1:0]  lat_size;
    logic        lat_sign;
    logic [15:0] lat_data;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic request;
    logic bad_align;
    logic start;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = {{24{sign & b[7]}}, b};
            SIZE_HALF: r = {{16{sign & h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed byte or halfword of a memory word.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic [15:0] data);
        logic [31:0] r;
        r = word;
        case (size)
            SIZE_BYTE: r[8*lane +: 8] = data[7:0];
            SIZE_HALF: begin
                if (lane[1]) r[31:16] = data;
                else         r[15:0]  = data;
            end
            default: r = word;
        endcase
        return r;
    endfunction

    assign request   = MemRead | MemWrite;
    assign bad_align = (MemDataSize == 2'b00)
                     || ((MemDataSize == SIZE_WORD) && (Address[1:0] != 2'b00))
                     || ((MemDataSize == SIZE_HALF) && Address[0]);
    assign start     = (state == IDLE) && request && !bad_align;

    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        Misaligned = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (bad_align) begin
                        Misaligned = 1'b1;
                    end else begin
                        Stall = 1'b1;
                        // A simultaneous read and write request is a store.
                        if (MemWrite)
                            state_next = (MemDataSize == SIZE_WORD) ? WRITE : RMW_READ;
                        else
                            state_next = READ;
                    end
                end
            end
            READ: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) state_next = DONE;
            end
            RMW_READ: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) state_next = RMW_WRITE;
            end
            RMW_WRITE: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_next = DONE;
            end
            WRITE: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat_lane <= 2'b00;
            lat_size <= 2'b00;
            lat_sign <= 1'b0;
            lat_data <= 16'h0000;
            addr_q   <= 30'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state <= state_next;
            if (start) begin
                lat_lane <= Address[1:0];
                lat_size <= MemDataSize;
                lat_sign <= MemDataSign;
                lat_data <= WriteData[15:0];
                addr_q   <= Address[31:2];
                wdata_q  <= WriteData;
            end
            if ((state == READ) && mem_ack)
                rdata_q <= extend_load(mem_rdata, lat_lane, lat_size, lat_sign);
            if ((state == RMW_READ) && mem_ack)
                wdata_q <= merge_store(mem_rdata, lat_lane, lat_size, lat_data);
        end
    end

    assign ReadData  = rdata_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed bench with a transaction-level reference model for
//            mem_access_unit.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemDataSize = 2'b00;
    logic        MemDataSign = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int tests = 0;
    int fails = 0;

    mem_access_unit dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemDataSize (MemDataSize),
        .MemDataSign (MemDataSign),
        .Address     (Address),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .Stall       (Stall),
        .Misaligned  (Misaligned),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory environment: 16 words, configurable ack latency.
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        hold_we = 1'b0;
    logic        force_ack = 1'b0;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'h0;
    logic [31:0] pl_val = 32'h0;

    assign mem_rdata = mem[mem_addr[5:2]];
    assign mem_ack   = force_ack | (mem_req && !(hold_we && mem_we) && (wait_cnt >= ack_delay));

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (mem_req && mem_ack && mem_we)
            mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_req && mem_ack) wait_cnt <= 0;
        else if (mem_req)       wait_cnt <= wait_cnt + 1;
        else                    wait_cnt <= 0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference model of the architectural effect of an access.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] size, input logic sign);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(addr[1:0]);
        v  = word >> sh;
        if (size == 2'b01) begin
            v = v & 32'hFF;
            if (sign && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (size == 2'b10) begin
            v = v & 32'hFFFF;
            if (sign && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] addr,
                                                input logic [1:0] size, input logic [31:0] data);
        logic [31:0] mask;
        int sh;
        sh   = 8 * int'(addr[1:0]);
        mask = (size == 2'b01) ? 32'hFF : (size == 2'b10) ? 32'hFFFF : 32'hFFFFFFFF;
        return (word & ~(mask << sh)) | ((data & mask) << sh);
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        is_load;
        logic [31:0] rd;
    } txn_t;

    txn_t        q[$];
    logic [31:0] exp_rd = 32'h0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_wdata = 32'h0;

    // Per-cycle comparison against the transaction queue and expected ReadData.
    always @(negedge clk) begin
        txn_t t;
        #2;
        if (reset) begin
            check("rst_mem_req", mem_req, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_stall", Stall, 0);
            check("rst_misaligned", Misaligned, 0);
            check("rst_read_data", ReadData, 32'h0);
            check("rst_mem_addr", mem_addr, 32'h0);
            check("rst_mem_wdata", mem_wdata, 32'h0);
            q.delete();
            exp_rd    = 32'h0;
            prev_wait = 1'b0;
        end else begin
            check("read_data", ReadData, exp_rd);
            if (!mem_req) check("we_without_req", mem_we, 0);
            if (mem_req && prev_wait) begin
                check("addr_stable", mem_addr, prev_addr);
                check("wdata_stable", mem_wdata, prev_wdata);
            end
            if (mem_req && mem_ack) begin
                if (q.size() == 0) begin
                    check("unexpected_txn", mem_addr, 32'hFFFFFFFF);
                end else begin
                    t = q.pop_front();
                    check("txn_we", mem_we, t.we);
                    check("txn_addr", mem_addr, t.addr);
                    if (t.we) check("txn_wdata", mem_wdata, t.wdata);
                    if (t.is_load) exp_rd = t.rd;
                end
                prev_wait = 1'b0;
            end else if (mem_req) begin
                prev_wait  = 1'b1;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    task automatic set_word(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        pl_idx = 4'(idx);
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic clear_inputs();
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemDataSize = 2'b00;
        MemDataSign = 1'b0;
        Address     = 32'h0;
        WriteData   = 32'h0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                          input string nm);
        logic        mis;
        int          ntx;
        int          cnt;
        int          idx;
        logic [31:0] aligned;
        logic [31:0] nw;
        mis     = (size == 2'b00) || (size == 2'b11 && addr[1:0] != 2'b00) || (size == 2'b10 && addr[0]);
        idx     = int'(addr[5:2]);
        aligned = addr & 32'hFFFFFFFC;
        ntx     = 0;
        ack_delay = delay;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; MemDataSize = size; MemDataSign = sign;
        Address = addr; WriteData = wdata;
        if (!mis) begin
            if (wr) begin
                nw = model_store(ref_mem[idx], addr, size, wdata);
                if (size == 2'b11) begin
                    q.push_back('{1'b1, aligned, nw, 1'b0, 32'h0});
                    ntx = 1;
                end else begin
                    q.push_back('{1'b0, aligned, 32'h0, 1'b0, 32'h0});
                    q.push_back('{1'b1, aligned, nw, 1'b0, 32'h0});
                    ntx = 2;
                end
                ref_mem[idx] = nw;
            end else begin
                q.push_back('{1'b0, aligned, 32'h0, 1'b1, model_load(ref_mem[idx], addr, size, sign)});
                ntx = 1;
            end
        end
        #1;
        check({nm, "_misaligned"}, Misaligned, mis);
        check({nm, "_stall_first"}, Stall, !mis);
        if (mis) begin
            check({nm, "_no_req"}, mem_req, 0);
            @(negedge clk);
            clear_inputs();
            #1 check({nm, "_no_req_after"}, mem_req, 0);
            return;
        end
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            // Unrelated requests while busy must have no effect.
            MemRead     = 1'b1;
            MemWrite    = 1'($urandom_range(1, 0));
            MemDataSize = 2'b11;
            Address     = $urandom & 32'h3C;
            WriteData   = $urandom;
            #1;
            if (Stall) cnt++;
            else break;
        end
        clear_inputs();
        check({nm, "_stall_cycles"}, cnt, 1 + ntx * (1 + delay));
        check({nm, "_req_low_done"}, mem_req, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        for (int i = 0; i < 16; i++) set_word(i, 32'h0);
        set_word(4, 32'h80FF7F01);
        set_word(5, 32'hA5B6C7D8);
        set_word(6, 32'h01020304);
        @(negedge clk);
        reset = 1'b0;

        access(1, 0, 2'b01, 1, 32'h13, 32'h0, 0, "lb_signed");
        check("lb_signed_lit", ReadData, 32'hFFFFFF80);
        access(1, 0, 2'b01, 0, 32'h13, 32'h0, 0, "lb_unsigned");
        check("lb_unsigned_lit", ReadData, 32'h00000080);
        access(1, 0, 2'b10, 1, 32'h12, 32'h0, 0, "lh_signed");
        check("lh_signed_lit", ReadData, 32'hFFFF80FF);
        check("lh_addr_lit", mem_addr, 32'h00000010);
        access(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, "lh_lo");
        access(1, 0, 2'b01, 1, 32'h11, 32'h0, 0, "lb_lane1");
        access(1, 0, 2'b11, 0, 32'h14, 32'h0, 1, "lw_wait1");

        set_word(4, 32'h11223344);
        access(0, 1, 2'b01, 0, 32'h11, 32'h000000AB, 0, "sb");
        check("sb_mem_lit", mem[4], 32'h1122AB44);
        access(0, 1, 2'b10, 0, 32'h16, 32'h1234BEEF, 2, "sh_wait2");
        access(1, 0, 2'b11, 0, 32'h14, 32'h0, 0, "lw_after_sh");

        access(1, 0, 2'b11, 0, 32'h02, 32'h0, 0, "lw_mis");
        access(1, 0, 2'b10, 0, 32'h01, 32'h0, 0, "lh_mis");
        access(0, 1, 2'b00, 0, 32'h00, 32'h5, 0, "size0_mis");
        check("mis_keeps_rd", ReadData, 32'hBEEFC7D8);

        access(0, 1, 2'b11, 0, 32'h18, 32'hCAFEF00D, 4, "sw_wait4");
        access(1, 1, 2'b01, 0, 32'h1B, 32'h0000007E, 0, "both_is_store");
        access(1, 0, 2'b11, 0, 32'h18, 32'h0, 0, "lw_after_sw");
        check("lw_after_sw_lit", ReadData, 32'h7EFEF00D);

        // Reset during RMW_WRITE with the write ack withheld.
        ack_delay = 0;
        hold_we   = 1'b1;
        @(negedge clk);
        MemWrite = 1'b1; MemDataSize = 2'b01; Address = 32'h19; WriteData = 32'h55;
        q.push_back('{1'b0, 32'h18, 32'h0, 1'b0, 32'h0});
        q.push_back('{1'b1, 32'h18, 32'h0, 1'b0, 32'h0});
        #1 check("abort_stall0", Stall, 1);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1;
        check("abort_in_rmw_write_req", mem_req, 1);
        check("abort_in_rmw_write_we", mem_we, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_req_drop", mem_req, 0);
        check("abort_stall_drop", Stall, 0);
        force_ack = 1'b1;
        @(negedge clk);
        #3 force_ack = 1'b0;
        hold_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_no_write", mem[6], 32'h7EFEF00D);
        access(1, 0, 2'b11, 0, 32'h10, 32'h0, 0, "lw_post_reset");
        check("lw_post_reset_lit", ReadData, 32'h1122AB44);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
